// File: rtl/ws2812_frame_ctrl.sv
// Frame sequencer for a WS2812-style pixel encoder: fetches each pixel from RAM, scales it by
// global brightness, reorders RGB->GRB, handshakes with the encoder and times the latch gap.
module ws2812_frame_ctrl #(
  parameter int unsigned NUM_LEDS    = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned RESET_US    = 300,
  parameter int unsigned TIMEOUT_CYC = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic [7:0]        brightness,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic [23:0]       enc_rgb,
  output logic              enc_tx_en,
  input  logic              enc_tx_done
);

  localparam int unsigned ResetCycles = CLK_FREQ_HZ / 1_000_000 * RESET_US;
  localparam int unsigned CntMax = (TIMEOUT_CYC > ResetCycles) ? TIMEOUT_CYC : ResetCycles;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0] LatchLast = CntW'(ResetCycles - 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StSend, StLatch} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       rgb_q, rgb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;
  logic              tx_en_q, tx_en_d;

  logic send_done, timeout, latch_end, frame_start;

  // (c * (b + 1)) >> 8 never exceeds 16 bits, so b = 255 passes c through exactly.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return 8'(prod >> 8);
  endfunction

  assign send_done   = (state_q == StSend) && enc_tx_done;
  assign timeout     = (state_q == StSend) && !enc_tx_done && (cnt_q == TimeoutLast);
  assign latch_end   = (state_q == StLatch) && (cnt_q == LatchLast);
  assign frame_start = ((state_q == StIdle) && start) || (latch_end && continuous);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      rgb_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      tx_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rgb_q   <= rgb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      tx_en_q <= tx_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: state_d = StWait;
      StWait:  state_d = StSend;
      StSend: begin
        if (enc_tx_done) state_d = (addr_q == LastAddr) ? StLatch : StFetch;
        else if (timeout) state_d = StLatch;
      end
      StLatch: if (latch_end) state_d = continuous ? StFetch : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered copies of decodes of the next state.
  always_comb begin
    cnt_d  = '0;
    addr_d = addr_q;
    rgb_d  = rgb_q;
    err_d  = err_q;
    if ((state_q == StSend || state_q == StLatch) && state_d == state_q) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (frame_start) begin
      addr_d = '0;
      err_d  = 1'b0;
    end else if (send_done && addr_q != LastAddr) begin
      addr_d = addr_q + ADDR_W'(1);
    end
    if (timeout) err_d = 1'b1;
    if (state_q == StWait) begin
      rgb_d = {scale(pix_data[15:8], brightness), scale(pix_data[23:16], brightness),
               scale(pix_data[7:0], brightness)};
    end
    busy_d  = (state_d != StIdle);
    rd_d    = (state_d == StFetch);
    tx_en_d = (state_d == StSend);
    done_d  = latch_end;
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign err        = err_q;
  assign pix_rd     = rd_q;
  assign pix_addr   = addr_q;
  assign enc_rgb    = rgb_q;
  assign enc_tx_en  = tx_en_q;

endmodule
